generic_dpram_sc: RTL and testbench
===================================

# generic_dpram_sc

Single-clock, dual-port RAM: one synchronous write port and one read port with a registered read address, depth 2^aw words of dw bits. It is the storage element under the synchronous FIFO (`generic_fifo_sc_b`). The FIFO drives the write port from its write pointer and the read port from its read pointer, with `rce`, `oe` and `wce` tied high. The read port gives one-cycle read latency with write-first behaviour on address collisions.

## Interface
Parameters:
- `aw`, default 8: address width; depth = 2^aw words.
- `dw`, default 8: data word width.

Ports:
- `clk`, input, 1: single clock for both ports; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-low.
- `rce`, input, 1: read clock enable; when high, `raddr` is captured on the edge.
- `oe`, input, 1: output enable; gates `dout` combinationally.
- `raddr`, input, aw: read address.
- `dout`, output, dw: read data.
- `wce`, input, 1: write clock enable.
- `we`, input, 1: write enable; a write needs `wce & we`.
- `waddr`, input, aw: write address.
- `di`, input, dw: write data.

## Operation
- Storage: array `mem[0 .. 2^aw-1]` of dw bits.
  - Reset does not clear it.
  - Contents are undefined (X in simulation) until written.
- Write:
  - On a rising edge with `rst`=1, `wce`=1 and `we`=1, `mem[waddr]` is set to `di`.
  - When `rst`=0, writes are suppressed.
- Read address register `ra` (aw bits):
  - On a rising edge with `rst`=0: `ra` is set to 0.
  - Else if `rce`=1: `ra` is set to `raddr`.
  - Else `ra` holds its value.
- Output: `dout` = `oe` ? `mem[ra]` : {dw{1'b0}}. This is a combinational read of the array at the registered address. There is no output register.
- Write-first collision: when a write to address A and a read capture of A occur on the same edge, `dout` after that edge shows the newly written `di`.
- Because `dout` reads `mem[ra]` continuously, a later write to the address held in `ra` updates `dout` after that write edge, even with `rce`=0.
- Address inputs are exactly aw bits, so there is no out-of-range case. Wrap-around of pointers is the caller's job.
- No full/empty or flow control inside the block. Every enabled write overwrites.

## Timing
- Read latency: address presented at edge N with `rce`=1 gives valid `dout` after edge N, within the same cycle before edge N+1. This is one clock of latency.
- Write latency: data written at edge N is readable at the next read capture, or at the same edge if the addresses collide (write-first).
- `oe` acts combinationally with zero cycles of delay.
- Reset:
  - `rst` is sampled only on the rising edge; there is no asynchronous path.
  - After a reset edge, `ra`=0 and `dout` = `mem[0]` if `oe`=1, otherwise 0.
  - Reset asserted mid-operation forces `ra` to 0 on that edge and blocks any write on that edge. Memory contents are preserved.
- Reset takes priority over `rce`, `wce` and `we` on the same edge.

## Test plan
- **Reset:** hold `rst`=0 for 2 edges with `we`=`wce`=1, `waddr`=3, `di`=8'hAA.
  - Required: `ra`=0.
  - Required: a later read of address 3 (after write data is known) shows no 8'hAA from the blocked write.
- **Basic write/read:** after reset, write 8'h11, 8'h22, 8'h33 to addresses 0, 1, 2, then read addresses 0, 1, 2 with `rce`=`oe`=1.
  - Required: `dout` = 11, 22, 33, each one edge after its address is presented.
- **Collision:** `mem[5]`=8'h44; on one edge write 8'h55 to address 5 and capture `raddr`=5.
  - Required: `dout`=8'h55 after that edge.
- **Enables:** capture address 1 (`dout`=22), then set `rce`=0 and change `raddr` to 2.
  - Required: `dout` stays 22.
  - Drive `oe`=0. Required: `dout`=0 immediately. Restore `oe`=1. Required: `dout`=22.
  - Write with `wce`=0 or `we`=0. Required: memory is unchanged.
- **Full depth:** write `di` = address XOR 8'hA5 to all 256 addresses, wrapping from 255 to 0, then read back sequentially.
  - Required: every word matches.
  - Required: rewriting address 0 after the wrap replaces its previous value.
- **Reset mid-read:** while streaming reads at address 7, assert `rst`=0 for one edge.
  - Required: `dout` switches to `mem[0]` after that edge.
  - Required: the array is intact (address 7 reads back correctly afterwards).

Source files
------------

// File: rtl/generic_dpram_sc.sv
// ----------------------------------------------------------------------------
// generic_dpram_sc
//
// Single-clock dual-port RAM used as the storage behind the synchronous FIFO.
// One synchronous write port, one read port with a registered read address and
// a combinational array read behind it. This gives one cycle of read latency
// and write-first behaviour when a write and a read capture hit the same word
// on the same edge.
//
// Parameters:
//   aw    - address width, depth is 2**aw words
//   dw    - data word width
//
// Ports:
//   clk   - clock for both ports, rising edge
//   rst   - synchronous active-low reset; clears the read address register and
//           blocks writes on that edge, memory contents are kept
//   rce   - read clock enable, captures raddr when high
//   oe    - output enable, combinationally forces dout to zero when low
//   raddr - read address
//   dout  - read data, mem[ra] gated by oe
//   wce   - write clock enable
//   we    - write enable, a write needs wce & we
//   waddr - write address
//   di    - write data
// ----------------------------------------------------------------------------
module generic_dpram_sc #(
    parameter int unsigned aw = 8,
    parameter int unsigned dw = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rce,
    input  logic          oe,
    input  logic [aw-1:0] raddr,
    output logic [dw-1:0] dout,
    input  logic          wce,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  logic [dw-1:0] di
);

    localparam int unsigned Depth = 1 << aw;

    // Storage is never reset; unwritten words stay undefined.
    logic [dw-1:0] mem [Depth];

    logic [aw-1:0] ra_q, ra_d;
    logic          mem_wr;

    // Reset wins over every enable on the same edge.
    always_comb begin
        mem_wr = rst & wce & we;
        ra_d   = ra_q;
        if (!rst) begin
            ra_d = '0;
        end else if (rce) begin
            ra_d = raddr;
        end
    end

    always_ff @(posedge clk) begin
        ra_q <= ra_d;
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[waddr] <= di;
        end
    end

    // Reading the array continuously at the registered address makes a write
    // to the captured word visible right after its edge (write-first), even
    // when no new address is captured.
    always_comb begin
        dout = '0;
        if (oe) begin
            dout = mem[ra_q];
        end
    end

endmodule

// File: tb/tb_generic_dpram_sc.sv
module tb_generic_dpram_sc;

    logic       clk;
    logic       rst;
    logic       rce;
    logic       oe;
    logic [7:0] raddr;
    logic [7:0] dout;
    logic       wce;
    logic       we;
    logic [7:0] waddr;
    logic [7:0] di;

    int tests_run;
    int tests_failed;

    generic_dpram_sc #(
        .aw(8),
        .dw(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rce  (rce),
        .oe   (oe),
        .raddr(raddr),
        .dout (dout),
        .wce  (wce),
        .we   (we),
        .waddr(waddr),
        .di   (di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain word array plus the address the read port points at.
    logic [7:0] m_mem [256];
    bit         m_val [256];
    int         m_ra;
    bit         m_ra_known;

    typedef struct {
        logic       rst;
        logic       rce;
        logic       oe;
        logic       wce;
        logic       we;
        logic [7:0] raddr;
        logic [7:0] waddr;
        logic [7:0] di;
        bit         chk;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [7:0] exp);
        tests_run++;
        if (dout !== exp) begin
            tests_failed++;
            $display("FAIL %s: dout=%02h expected=%02h at %0t", name, dout, exp, $time);
        end
    endtask

    // Apply one rising edge, updating the model from the inputs as they stand.
    task automatic cycle();
        if (!rst) begin
            m_ra       = 0;
            m_ra_known = 1'b1;
        end else begin
            if (wce && we) begin
                m_mem[waddr] = di;
                m_val[waddr] = 1'b1;
            end
            if (rce) begin
                m_ra       = int'(raddr);
                m_ra_known = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        if (!oe) begin
            check(name, 8'h00);
        end else if (m_ra_known && m_val[m_ra]) begin
            check(name, m_mem[m_ra]);
        end
    endtask

    task automatic set_in(input logic r, input logic rc, input logic o, input logic wc,
                          input logic w, input logic [7:0] ra, input logic [7:0] wa,
                          input logic [7:0] d);
        rst = r; rce = rc; oe = o; wce = wc; we = w; raddr = ra; waddr = wa; di = d;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_ra         = 0;
        m_ra_known   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            m_val[i] = 1'b0;
            m_mem[i] = 8'h00;
        end
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        //            rst   rce   oe    wce   we    raddr  waddr  di     chk exp
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h03, 8'h3C, 0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h09, 8'h03, 8'hAA, 0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h09, 8'h03, 8'hAA, 0, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 8'h00, 8'h11, 1, 8'h3C};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h01, 8'h22, 1, 8'h11};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 8'h33, 1, 8'h22};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00, 1, 8'h33};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 8'h05, 8'h44, 1, 8'h33};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 8'h05, 8'h55, 1, 8'h55};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 1, 8'h22};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00, 1, 8'h22};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00, 1, 8'h00};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00, 1, 8'h22};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h01, 8'hEE, 1, 8'h22};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 8'h01, 8'hEE, 1, 8'h22};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 8'h01, 8'h77, 1, 8'h77};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            set_in(vecs[i].rst, vecs[i].rce, vecs[i].oe, vecs[i].wce, vecs[i].we,
                   vecs[i].raddr, vecs[i].waddr, vecs[i].di);
            cycle();
            if (vecs[i].chk) check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // oe is purely combinational: no edge between change and check.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00);
        #1;
        check("oe_low_now", 8'h00);
        oe = 1'b1;
        #1;
        check("oe_high_now", 8'h77);

        // Full depth: 257 writes so the last one wraps and rewrites address 0.
        for (int a = 0; a < 257; a++) begin
            set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'(a),
                   (a == 256) ? 8'hC3 : (8'(a) ^ 8'hA5));
            cycle();
        end
        for (int a = 0; a < 256; a++) begin
            set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'(a), 8'h00, 8'h00);
            cycle();
            check($sformatf("depth%0d", a), (a == 0) ? 8'hC3 : (8'(a) ^ 8'hA5));
        end

        // Reset in the middle of a read stream at address 7.
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 8'h00, 8'h00);
        cycle();
        check("stream7_a", 8'hA2);
        cycle();
        check("stream7_b", 8'hA2);
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h07, 8'h07, 8'h99);
        cycle();
        check("mid_reset_ra0", 8'hC3);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 8'h00, 8'h00);
        cycle();
        check("after_reset7", 8'hA2);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 31) != 0), 1'($urandom), ($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                   8'($urandom), 8'($urandom));
            // Bias reads toward recently written words to exercise collisions.
            if ($urandom_range(0, 3) == 0) raddr = waddr;
            cycle();
            check_model($sformatf("rand%0d", n));
            if ($urandom_range(0, 7) == 0) begin
                oe = ~oe;
                #1;
                check_model($sformatf("rand_oe%0d", n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
